// File: rtl/outport_uart_pkg.sv
// outport_uart_pkg: shared types and helpers for the outport UART tracer.
//   uart_state_t  - transmitter FSM states (PARITY used only when
//                   OUTPORT_PARITY_EN is defined)
//   baud_width()  - bit width needed for a 0..cpb-1 baud counter
package outport_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // A counter spanning 0..cpb-1 needs at least one bit even for cpb=2.
    function automatic int baud_width(input int cpb);
        return (cpb <= 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/outport_uart_if.sv
// outport_uart_if: bundle between the CPU-side monitor and the UART tracer.
//   outport    - value under observation (CPU outport)
//   tx         - UART serial line, idle high
//   busy       - frame in flight or FIFO non-empty
//   overflow   - sticky capture-dropped flag
//   fifo_count - current FIFO occupancy
// Modports: slave = the tracer, master = whoever drives outport.
interface outport_uart_if #(
    parameter int n     = 8,
    parameter int DEPTH = 4
);
    logic [n-1:0]                 outport;
    logic                         tx;
    logic                         busy;
    logic                         overflow;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;

    modport slave  (input outport, output tx, busy, overflow, fifo_count);
    modport master (output outport, input tx, busy, overflow, fifo_count);
endinterface

// File: rtl/outport_uart_sync_fifo.sv
// sync_fifo: single-clock FIFO with an explicit occupancy counter.
//   clk, reset (async, active low)
//   push/wdata - write request; accepted when not full, or when full and a
//                pop happens in the same cycle
//   pop/rdata  - rdata is the head (show-ahead); pop ignored when empty
//   count/full/empty - occupancy status
module sync_fifo #(
    parameter int n     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [n-1:0]               wdata,
    output logic [n-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [n-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_pop, do_push;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write if the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/outport_uart.sv
// outport_uart: captures every new CPU outport value into a FIFO and sends
// each one on a UART line (LSB first, 1 start, 1 stop).
//   clk, reset (async, active low)
//   bus.outport in; bus.tx / busy / overflow / fifo_count out
// Optional: define OUTPORT_PARITY_EN to add an even-parity bit after data.
module outport_uart
    import outport_uart_pkg::*;
#(
    parameter int n            = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 4
) (
    input  logic           clk,
    input  logic           reset,
    outport_uart_if.slave  bus
);
    localparam int BW = baud_width(CLKS_PER_BIT);
    localparam int IW = $clog2(n);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT-1);
    localparam logic [IW-1:0] LAST_BIT = IW'(n-1);

    uart_state_t   state_q;
    logic [BW-1:0] baud_q;
    logic [IW-1:0] bit_q;
    logic [n-1:0]  shift_q, prev_q, rdata;
    logic          first_q, tx_q, busy_q, ovf_q;
    logic [CW-1:0] count, cnt_next;
    logic          cap, pop, push_acc, full, empty, next_idle;
`ifdef OUTPORT_PARITY_EN
    logic          par_q;
`endif

    // The first cycle after reset always captures, then only on change.
    assign cap      = first_q | (bus.outport != prev_q);
    assign pop      = (state_q == IDLE) & ~empty;
    assign push_acc = cap & (~full | pop);
    assign cnt_next = count + CW'(push_acc) - CW'(pop);
    assign next_idle = ((state_q == IDLE) & empty) |
                       ((state_q == STOP) & (baud_q == BAUD_MAX));

    sync_fifo #(.n(n), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cap),
        .pop   (pop),
        .wdata (bus.outport),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= '0;
            first_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            prev_q  <= bus.outport;
            first_q <= 1'b0;
            if (cap & full & ~pop) ovf_q <= 1'b1;
        end
    end

    // tx is updated together with the state so it is a clean register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef OUTPORT_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            busy_q <= ~next_idle | (cnt_next != '0);
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        state_q <= START;
                        baud_q  <= '0;
                        shift_q <= rdata;
                        tx_q    <= 1'b0;
`ifdef OUTPORT_PARITY_EN
                        par_q   <= ^rdata;
`endif
                    end
                end
                START: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q <= '0;
                        if (bit_q == LAST_BIT) begin
`ifdef OUTPORT_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + IW'(1);
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`ifdef OUTPORT_PARITY_EN
                PARITY: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q  <= '0;
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_count = count;
endmodule

// File: tb/tb_outport_uart.sv
// tb_outport_uart: directed stimulus pushes expected frame values into a
// scoreboard queue; a tx-line monitor decodes frames and pops/compares.
module tb_outport_uart;
    localparam int N   = 8;
    localparam int CPB = 4;
    localparam int DEP = 4;
`ifdef OUTPORT_PARITY_EN
    localparam int FB  = N + 3;
`else
    localparam int FB  = N + 2;
`endif
    localparam int FC  = FB * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    outport_uart_if #(.n(N), .DEPTH(DEP)) bus ();
    outport_uart #(.n(N), .CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard + monitor ----------------
    logic [N-1:0] exp_q[$];
    logic [FB-1:0] sv;
    bit  mact = 0, glitch = 0, gap_chk = 0;
    logic tx_prev = 1'b1;
    int  mc = 0, last_start = 0, m_starts = 0;

    task automatic frame_done();
        logic [N-1:0] e;
        if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_frame: got %0h expected none", sv[N:1]);
        end else begin
            e = exp_q.pop_front();
            check("frame_data", 32'(sv[N:1]), 32'(e));
            check("framing", {29'd0, glitch, sv[0], sv[FB-1]}, 32'h1);
`ifdef OUTPORT_PARITY_EN
            check("parity", 32'(sv[N+1]), 32'(^e));
`endif
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mact = 0;
        end else if (!mact) begin
            if (tx_prev && !bus.tx) begin
                mact = 1; mc = 0; glitch = 0; sv = '0; sv[0] = bus.tx;
                if (gap_chk) check("b2b_period", cyc - last_start, FC + 1);
                last_start = cyc;
                m_starts++;
            end
        end else begin
            mc++;
            if (mc % CPB == 0) sv[mc/CPB] = bus.tx;
            else if (bus.tx !== sv[mc/CPB]) glitch = 1;
            if (mc == FC - 1) begin
                mact = 0;
                frame_done();
            end
        end
        tx_prev = reset ? bus.tx : 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [N-1:0] v, input bit expect_tx);
        @(negedge clk);
        bus.outport = v;
        if (expect_tx) exp_q.push_back(v);
    endtask

    task automatic wait_start(input int s0);
        int t = 0;
        while (m_starts == s0 && t < 200) begin @(negedge clk); t++; end
        check("start_seen", 32'(m_starts != s0), 32'h1);
    endtask

    task automatic wait_idle(input int limit);
        int t = 0;
        while (!(bus.busy == 1'b0 && exp_q.size() == 0) && t < limit) begin
            @(negedge clk); t++;
        end
        check("drain", 32'(exp_q.size() == 0 && bus.busy == 1'b0), 32'h1);
        @(negedge clk);
    endtask

    initial begin
        int s0, chg;
        bus.outport = '0;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.tx), 32'h1);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_ovf", 32'(bus.overflow), 32'h0);
        check("rst_count", 32'(bus.fifo_count), 32'h0);

        // T1: release with 00 held -> one frame
        @(negedge clk);
        reset = 1'b1; chg = cyc; s0 = m_starts;
        exp_q.push_back(8'h00);
        wait_start(s0);
        check("t1_latency", last_start - chg, 32'd2);
        check("t1_busy_hi", 32'(bus.busy), 32'h1);
        wait_idle(200);
        check("t1_busy_lo", 32'(bus.busy), 32'h0);
        check("t1_tx_idle", 32'(bus.tx), 32'h1);

        // T2: 00 -> A5, start edge 2 cycles after change
        s0 = m_starts;
        drive(8'hA5, 1); chg = cyc;
        wait_start(s0);
        check("t2_latency", last_start - chg, 32'd2);
        wait_idle(200);

        // T3: FIFO full while a pop coincides with a capture
        s0 = m_starts;
        drive(8'hB0, 1);
        drive(8'hB1, 1);
        drive(8'hB2, 1);
        drive(8'hB3, 1);
        drive(8'hB4, 1);
        wait_start(s0);
        gap_chk = 1;
        while (cyc < last_start + 40) @(negedge clk);
        check("t3_full", 32'(bus.fifo_count), 32'd4);
        bus.outport = 8'hB5; exp_q.push_back(8'hB5);
        @(negedge clk);
        check("t3_count_kept", 32'(bus.fifo_count), 32'd4);
        check("t3_no_ovf", 32'(bus.overflow), 32'h0);
        wait_idle(400);
        gap_chk = 0;

        // T4: six consecutive changes during a frame -> overflow
        s0 = m_starts;
        drive(8'hC0, 1);
        wait_start(s0);
        gap_chk = 1;
        for (int i = 1; i <= 6; i++) drive(N'(i), i <= 4);
        @(negedge clk);
        check("t4_count", 32'(bus.fifo_count), 32'd4);
        check("t4_ovf", 32'(bus.overflow), 32'h1);
        wait_idle(400);
        gap_chk = 0;
        check("t4_ovf_sticky", 32'(bus.overflow), 32'h1);

        // T5: 07 (odd weight -> parity 1 when parity is built in)
        drive(8'h07, 1);
        wait_idle(200);

        // T6: reset during data bit 3 (D3 bit3 = 0, so tx is low there)
        s0 = m_starts;
        drive(8'hD3, 1);
        wait_start(s0);
        while (cyc < last_start + 17) @(negedge clk);
        check("t6_tx_low_before", 32'(bus.tx), 32'h0);
        reset = 1'b0;
        #1;
        check("t6_tx", 32'(bus.tx), 32'h1);
        check("t6_count", 32'(bus.fifo_count), 32'h0);
        check("t6_ovf", 32'(bus.overflow), 32'h0);
        check("t6_busy", 32'(bus.busy), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1; chg = cyc; s0 = m_starts;
        exp_q.push_back(8'hD3);
        wait_start(s0);
        check("t6_relatency", last_start - chg, 32'd2);
        wait_idle(200);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/outport_uart.md
Name: outport_uart

Overview:
- Downstream consumer of the picoMIPS CPU `outport` (the combinational ALU result, n bits).
- Watches `outport` for changes and captures each new value into a small FIFO.
- Transmits each captured value on a UART line: LSB first, 1 start bit, 1 stop bit.
- Gives the bench and the board a serial trace of every value the program produces, with no change to the CPU.

Parameters:
- n, 8: data width; must equal the CPU n. Legal range 5..9.
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200). Minimum 2.
- DEPTH, 4: FIFO entries. Power of two, ≥2.

Ports:
- clk  input  1  system clock, shared with cpu.
- reset  input  1  asynchronous, active-low master reset.
- outport  input  n  value to monitor, from the cpu outport.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- overflow  output  1  sticky; set when a capture is dropped because the FIFO is full.
- fifo_count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - FSM to IDLE; FIFO pointers cleared.
  - prev register cleared; first_flag set.
- Capture (registered):
  - Each rising clk, compute cap = first_flag | (outport != prev).
  - prev <= outport; first_flag <= 0.
  - So the first cycle after reset release always captures.
  - Consecutive identical values are captured only once.
- Push:
  - If cap and the FIFO is not full: write outport, count+1.
  - If cap and full with no pop in the same cycle: value dropped, overflow <= 1 until reset.
  - If cap and full with a pop in the same cycle: push accepted, count unchanged, no overflow.
- Pop: occurs only on the IDLE->START transition. The head is loaded into the shift register in that same cycle.
- FSM states IDLE, START, DATA, STOP. baud_cnt counts 0..CLKS_PER_BIT-1; bit_idx counts 0..n-1.
  - IDLE: tx=1. If count>0: pop, go to START, baud_cnt=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and bit_idx+1. After bit n-1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Back-to-back frames: IDLE lasts exactly 1 cycle between frames when the FIFO is non-empty. Frame period is (n+2)*CLKS_PER_BIT + 1 cycles.
- Latency: a value captured with the FIFO empty and FSM in IDLE is pushed at clk edge k. Pop happens at edge k+1. The start bit appears on tx after edge k+1, i.e. 2 cycles after outport changes.
- tx, busy and overflow are registered outputs; no combinational path from outport to tx.
- busy = (state!=IDLE) | (count!=0).
- Reset asserted mid-frame: tx goes high immediately, queued data is lost, and the first post-reset value is re-captured.
- Wrap-around: FIFO read and write pointers are log2(DEPTH) bits and wrap naturally. A separate count register distinguishes full from empty.

Optional Feature:
- Macro: OUTPORT_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the n data bits) for CLKS_PER_BIT cycles.
  - Frame becomes n+3 bits.
- Undefined: no PARITY state; frame is n+2 bits (8N1 for n=8).

Decomposition:
- Package outport_uart_pkg holds:
  - the FSM state enum uart_state_t {IDLE, START, DATA, PARITY, STOP};
  - the baud-counter width function.
- One sub-module, sync_fifo:
  - parameters n, DEPTH;
  - ports clk, reset, push, pop, wdata, rdata, count, full, empty;
  - supports simultaneous push and pop when full.
- Change detection and the UART FSM live in outport_uart.

Test Plan (all with n=8, CLKS_PER_BIT=4, DEPTH=4):
- Release reset with outport=8'h00 held -> one frame. tx low for 4 cycles, then 32 cycles of 0, then 4 cycles high. busy falls after the stop bit.
- outport steps 8'h00 -> 8'hA5 after the first frame -> frame with data bits 1,0,1,0,0,1,0,1 (LSB first). Start edge occurs 2 cycles after the change.
- outport changes on 6 consecutive cycles (01..06) while a frame is active:
  - fifo_count reaches 4 and overflow=1;
  - only the values that fit are transmitted, in order;
  - frames are separated by exactly 1 idle cycle.
- FIFO full, pop coincides with a new capture -> no overflow; fifo_count stays 4.
- Assert reset during DATA bit 3 -> tx=1 within the same cycle, fifo_count=0, overflow=0. After release, the current outport is retransmitted.
- With OUTPORT_PARITY_EN, send 8'h07 -> parity bit 1 follows the data bits, and the frame is 44 cycles long.
